// File: rtl/branch_resolver_pkg.sv
// Shared branch-resolution types: op codes, producer tags and the in-flight
// branch queue entry.
package branch_resolver_pkg;

    localparam int TAG_W             = 4;
    localparam int BP_SIZE_W_DEFAULT = 7;

    typedef logic [TAG_W-1:0] tag_t;
    localparam tag_t NO_TAG = '0;

    // Encoding matches the decoder's op field.
    typedef enum logic [4:0] {
        OP_NOP  = 5'd0,
        OP_JAL  = 5'd1,
        OP_JALR = 5'd2,
        OP_BEQ  = 5'd3,
        OP_BNE  = 5'd4,
        OP_BLT  = 5'd5,
        OP_BGE  = 5'd6,
        OP_BLTU = 5'd7,
        OP_BGEU = 5'd8
    } op_e;

    typedef struct packed {
        logic        valid;
        op_e         op;
        logic [31:0] pc;
        logic [31:0] imm;
        logic        pred_taken;
        tag_t        rs1_tag;
        logic [31:0] rs1_val;
        tag_t        rs2_tag;
        logic [31:0] rs2_val;
    } brq_entry_t;

    function automatic logic is_cond_branch(op_e op);
        return (op == OP_BEQ)  || (op == OP_BNE)  || (op == OP_BLT) ||
               (op == OP_BGE)  || (op == OP_BLTU) || (op == OP_BGEU);
    endfunction

endpackage

// File: rtl/branch_resolver_if.sv
// Fetch/predictor <-> branch resolver bundle: enqueue, CDB snoop and the
// training/redirect return path.
interface branch_resolver_if #(
    parameter int BP_SIZE_W = branch_resolver_pkg::BP_SIZE_W_DEFAULT
);
    logic                          enq_valid;
    logic [4:0]                    enq_op;
    logic [31:0]                   enq_pc;
    logic [31:0]                   enq_imm;
    logic                          enq_pred_taken;
    branch_resolver_pkg::tag_t     enq_rs1_tag;
    branch_resolver_pkg::tag_t     enq_rs2_tag;
    logic [31:0]                   enq_rs1_val;
    logic [31:0]                   enq_rs2_val;
    logic                          enq_ready;
    branch_resolver_pkg::tag_t     cdb_tag;
    logic [31:0]                   cdb_val;
    logic                          upd_valid;
    logic [BP_SIZE_W-1:0]          upd_idx;
    logic [29-BP_SIZE_W:0]         upd_pc_tag;
    logic                          upd_taken;
    logic                          predict_fail;
    logic [31:0]                   redirect_addr;
    logic                          brq_empty;

    modport master (
        output enq_valid, enq_op, enq_pc, enq_imm, enq_pred_taken,
               enq_rs1_tag, enq_rs2_tag, enq_rs1_val, enq_rs2_val,
               cdb_tag, cdb_val,
        input  enq_ready, upd_valid, upd_idx, upd_pc_tag, upd_taken,
               predict_fail, redirect_addr, brq_empty
    );

    modport slave (
        input  enq_valid, enq_op, enq_pc, enq_imm, enq_pred_taken,
               enq_rs1_tag, enq_rs2_tag, enq_rs1_val, enq_rs2_val,
               cdb_tag, cdb_val,
        output enq_ready, upd_valid, upd_idx, upd_pc_tag, upd_taken,
               predict_fail, redirect_addr, brq_empty
    );
endinterface

// File: rtl/branch_cond_eval.sv
// Combinational conditional-branch evaluator; also usable by the ALU.
module branch_cond_eval
    import branch_resolver_pkg::*;
(
    input  op_e         op_i,
    input  logic [31:0] rs1_i,
    input  logic [31:0] rs2_i,
    output logic        taken_o
);
    always_comb begin
        taken_o = 1'b0;
        case (op_i)
            OP_BEQ:  taken_o = (rs1_i == rs2_i);
            OP_BNE:  taken_o = (rs1_i != rs2_i);
            OP_BLT:  taken_o = ($signed(rs1_i) <  $signed(rs2_i));
            OP_BGE:  taken_o = ($signed(rs1_i) >= $signed(rs2_i));
            OP_BLTU: taken_o = (rs1_i <  rs2_i);
            OP_BGEU: taken_o = (rs1_i >= rs2_i);
            default: taken_o = 1'b0;
        endcase
    end
endmodule

// File: rtl/branch_resolver.sv
// In-order branch queue: waits for operands on the CDB, resolves the head,
// emits predictor training and flushes on a mispredict.
module branch_resolver
    import branch_resolver_pkg::*;
#(
    parameter int BRQ_SIZE_W = 2,
    parameter int BP_SIZE_W  = BP_SIZE_W_DEFAULT
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic             rdy_in,
    branch_resolver_if.slave bus
);
    localparam int DEPTH = 1 << BRQ_SIZE_W;
    localparam int CNT_W = BRQ_SIZE_W + 1;

    typedef logic [BRQ_SIZE_W-1:0] ptr_t;

    brq_entry_t [DEPTH-1:0] ent_q, ent_d;
    ptr_t                   head_q, head_d, tail_q, tail_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;

    logic                   upd_valid_q, upd_valid_d;
    logic                   upd_taken_q, upd_taken_d;
    logic [BP_SIZE_W-1:0]   upd_idx_q, upd_idx_d;
    logic [29-BP_SIZE_W:0]  upd_tag_q, upd_tag_d;
    logic                   fail_q, fail_d;
    logic [31:0]            redir_q, redir_d;

    brq_entry_t head_e, new_ent;
    logic       head_taken, resolve, mispredict, enq_fire, deq_fire, enq_ready;

    assign head_e = ent_q[head_q];

    branch_cond_eval u_eval (
        .op_i    (head_e.op),
        .rs1_i   (head_e.rs1_val),
        .rs2_i   (head_e.rs2_val),
        .taken_o (head_taken)
    );

    // Tags are checked as stored, so a same-cycle CDB hit resolves next cycle.
    assign resolve    = head_e.valid && (head_e.rs1_tag == NO_TAG) && (head_e.rs2_tag == NO_TAG);
    assign mispredict = resolve && (head_taken != head_e.pred_taken);
    assign enq_ready  = (cnt_q != CNT_W'(DEPTH));
    assign enq_fire   = rdy_in && bus.enq_valid && enq_ready &&
                        is_cond_branch(op_e'(bus.enq_op)) && !mispredict;
    assign deq_fire   = rdy_in && resolve && !mispredict;

    always_comb begin
        new_ent            = '0;
        new_ent.valid      = 1'b1;
        new_ent.op         = op_e'(bus.enq_op);
        new_ent.pc         = bus.enq_pc;
        new_ent.imm        = bus.enq_imm;
        new_ent.pred_taken = bus.enq_pred_taken;
        new_ent.rs1_tag    = bus.enq_rs1_tag;
        new_ent.rs1_val    = bus.enq_rs1_val;
        new_ent.rs2_tag    = bus.enq_rs2_tag;
        new_ent.rs2_val    = bus.enq_rs2_val;
        if (bus.cdb_tag != NO_TAG && bus.enq_rs1_tag == bus.cdb_tag) begin
            new_ent.rs1_tag = NO_TAG;
            new_ent.rs1_val = bus.cdb_val;
        end
        if (bus.cdb_tag != NO_TAG && bus.enq_rs2_tag == bus.cdb_tag) begin
            new_ent.rs2_tag = NO_TAG;
            new_ent.rs2_val = bus.cdb_val;
        end
    end

    always_comb begin
        ent_d       = ent_q;
        head_d      = head_q;
        tail_d      = tail_q;
        cnt_d       = cnt_q;
        upd_valid_d = 1'b0;
        fail_d      = 1'b0;
        upd_taken_d = upd_taken_q;
        upd_idx_d   = upd_idx_q;
        upd_tag_d   = upd_tag_q;
        redir_d     = redir_q;

        if (rdy_in) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (ent_q[i].valid && bus.cdb_tag != NO_TAG) begin
                    if (ent_q[i].rs1_tag == bus.cdb_tag) begin
                        ent_d[i].rs1_tag = NO_TAG;
                        ent_d[i].rs1_val = bus.cdb_val;
                    end
                    if (ent_q[i].rs2_tag == bus.cdb_tag) begin
                        ent_d[i].rs2_tag = NO_TAG;
                        ent_d[i].rs2_val = bus.cdb_val;
                    end
                end
            end

            if (resolve) begin
                upd_valid_d = 1'b1;
                upd_taken_d = head_taken;
                upd_idx_d   = head_e.pc[1+BP_SIZE_W:2];
                upd_tag_d   = head_e.pc[31:2+BP_SIZE_W];
            end

            if (mispredict) begin
                // Everything younger than the head is wrong-path.
                fail_d  = 1'b1;
                redir_d = head_taken ? (head_e.pc + head_e.imm) : (head_e.pc + 32'd4);
                for (int i = 0; i < DEPTH; i++) ent_d[i].valid = 1'b0;
                head_d  = tail_q;
                cnt_d   = '0;
            end else begin
                if (deq_fire) begin
                    ent_d[head_q].valid = 1'b0;
                    head_d              = head_q + ptr_t'(1);
                end
                if (enq_fire) begin
                    ent_d[tail_q] = new_ent;
                    tail_d        = tail_q + ptr_t'(1);
                end
                case ({enq_fire, deq_fire})
                    2'b10:   cnt_d = cnt_q + CNT_W'(1);
                    2'b01:   cnt_d = cnt_q - CNT_W'(1);
                    default: cnt_d = cnt_q;
                endcase
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            ent_q       <= '0;
            head_q      <= '0;
            tail_q      <= '0;
            cnt_q       <= '0;
            upd_valid_q <= 1'b0;
            upd_taken_q <= 1'b0;
            upd_idx_q   <= '0;
            upd_tag_q   <= '0;
            fail_q      <= 1'b0;
            redir_q     <= '0;
        end else begin
            ent_q       <= ent_d;
            head_q      <= head_d;
            tail_q      <= tail_d;
            cnt_q       <= cnt_d;
            upd_valid_q <= upd_valid_d;
            upd_taken_q <= upd_taken_d;
            upd_idx_q   <= upd_idx_d;
            upd_tag_q   <= upd_tag_d;
            fail_q      <= fail_d;
            redir_q     <= redir_d;
        end
    end

    assign bus.enq_ready     = enq_ready;
    assign bus.brq_empty     = (cnt_q == '0);
    assign bus.upd_valid     = upd_valid_q;
    assign bus.upd_taken     = upd_taken_q;
    assign bus.upd_idx       = upd_idx_q;
    assign bus.upd_pc_tag    = upd_tag_q;
    assign bus.predict_fail  = fail_q;
    assign bus.redirect_addr = redir_q;
endmodule

// File: tb/tb_branch_resolver.sv
// Scoreboard bench for branch_resolver: expected training/redirect results are
// queued at enqueue time and popped as upd_valid pulses appear.
module tb_branch_resolver;
    import branch_resolver_pkg::*;

    localparam int BRQ_W = 2;
    localparam int BP_W  = 7;

    logic clk_in = 1'b0;
    logic rst_in;
    logic rdy_in;

    always #5 clk_in = ~clk_in;

    branch_resolver_if #(.BP_SIZE_W(BP_W)) bus();

    branch_resolver #(.BRQ_SIZE_W(BRQ_W), .BP_SIZE_W(BP_W)) dut (
        .clk_in (clk_in),
        .rst_in (rst_in),
        .rdy_in (rdy_in),
        .bus    (bus.slave)
    );

    typedef struct packed {
        logic             taken;
        logic             fail;
        logic [31:0]      redirect;
        logic [BP_W-1:0]  idx;
        logic [29-BP_W:0] pctag;
    } exp_t;

    exp_t sb[$];
    int   pulse_cyc[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;

    function automatic exp_t model(op_e op, logic [31:0] pc, logic [31:0] imm,
                                   logic pred, logic [31:0] a, logic [31:0] b);
        exp_t m;
        logic t;
        case (op)
            OP_BEQ:  t = (a == b);
            OP_BNE:  t = (a != b);
            OP_BLT:  t = ($signed(a) <  $signed(b));
            OP_BGE:  t = ($signed(a) >= $signed(b));
            OP_BLTU: t = (a <  b);
            OP_BGEU: t = (a >= b);
            default: t = 1'b0;
        endcase
        m.taken    = t;
        m.fail     = (t != pred);
        m.redirect = t ? (pc + imm) : (pc + 32'd4);
        m.idx      = pc[BP_W+1:2];
        m.pctag    = pc[31:BP_W+2];
        return m;
    endfunction

    // Advance n cycles, consuming any training pulse against the scoreboard.
    task automatic run_cycles(int n);
        exp_t e;
        for (int k = 0; k < n; k++) begin
            @(negedge clk_in);
            if (bus.upd_valid === 1'b1) begin
                pulse_cyc.push_back(cyc);
                n_tests++;
                if (sb.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_pulse cyc=%0d: got upd_valid=1 idx=%h, required no pulse",
                             cyc, bus.upd_idx);
                end else begin
                    e = sb.pop_front();
                    if ({bus.upd_taken, bus.predict_fail, bus.upd_idx, bus.upd_pc_tag} !==
                        {e.taken, e.fail, e.idx, e.pctag}) begin
                        n_fail++;
                        $display("FAIL upd_fields cyc=%0d: got taken=%b fail=%b idx=%h tag=%h, required taken=%b fail=%b idx=%h tag=%h",
                                 cyc, bus.upd_taken, bus.predict_fail, bus.upd_idx, bus.upd_pc_tag,
                                 e.taken, e.fail, e.idx, e.pctag);
                    end
                    if (e.fail) begin
                        n_tests++;
                        if (bus.redirect_addr !== e.redirect) begin
                            n_fail++;
                            $display("FAIL redirect cyc=%0d: got %h, required %h",
                                     cyc, bus.redirect_addr, e.redirect);
                        end
                    end
                end
            end else if (bus.predict_fail !== 1'b0) begin
                n_tests++;
                n_fail++;
                $display("FAIL lone_predict_fail cyc=%0d: got predict_fail=%b, required 0",
                         cyc, bus.predict_fail);
            end
            @(posedge clk_in);
            #1;
            cyc++;
        end
    endtask

    task automatic enq_br(op_e op, logic [31:0] pc, logic [31:0] imm, logic pred,
                          tag_t t1, logic [31:0] v1, tag_t t2, logic [31:0] v2);
        bus.enq_valid      = 1'b1;
        bus.enq_op         = op;
        bus.enq_pc         = pc;
        bus.enq_imm        = imm;
        bus.enq_pred_taken = pred;
        bus.enq_rs1_tag    = t1;
        bus.enq_rs1_val    = v1;
        bus.enq_rs2_tag    = t2;
        bus.enq_rs2_val    = v2;
        run_cycles(1);
        bus.enq_valid      = 1'b0;
    endtask

    task automatic test_reset();
        rst_in = 1'b1;
        run_cycles(2);
        n_tests++;
        if ({bus.upd_valid, bus.predict_fail, bus.upd_taken, bus.brq_empty, bus.enq_ready} !== 5'b00011 ||
            bus.redirect_addr !== 32'h0 || bus.upd_idx !== '0 || bus.upd_pc_tag !== '0) begin
            n_fail++;
            $display("FAIL reset_state: got v=%b f=%b t=%b empty=%b rdy=%b redir=%h idx=%h tag=%h, required 0/0/0/1/1/0/0/0",
                     bus.upd_valid, bus.predict_fail, bus.upd_taken, bus.brq_empty, bus.enq_ready,
                     bus.redirect_addr, bus.upd_idx, bus.upd_pc_tag);
        end
        rst_in = 1'b0;
        run_cycles(1);
    endtask

    task automatic test_non_branch();
        enq_br(OP_JAL, 32'h80, 32'h10, 1'b0, 4'd0, 32'd0, 4'd0, 32'd0);
        n_tests++;
        if (bus.brq_empty !== 1'b1) begin
            n_fail++;
            $display("FAIL jal_ignored: got brq_empty=%b, required 1", bus.brq_empty);
        end
        run_cycles(3);
    endtask

    task automatic test_ready_operands();
        int c0;
        c0 = cyc;
        sb.push_back(model(OP_BEQ, 32'h100, 32'h20, 1'b0, 32'd5, 32'd5));
        enq_br(OP_BEQ, 32'h100, 32'h20, 1'b0, 4'd0, 32'd5, 4'd0, 32'd5);
        n_tests++;
        if (bus.brq_empty !== 1'b0) begin
            n_fail++;
            $display("FAIL enq_nonempty: got brq_empty=%b, required 0", bus.brq_empty);
        end
        run_cycles(3);
        n_tests++;
        if (pulse_cyc.size() == 0 || pulse_cyc[pulse_cyc.size()-1] != c0 + 2) begin
            n_fail++;
            $display("FAIL resolve_latency: got pulse at cyc %0d, required %0d",
                     (pulse_cyc.size() == 0) ? -1 : pulse_cyc[pulse_cyc.size()-1], c0 + 2);
        end
        n_tests++;
        if (bus.brq_empty !== 1'b1) begin
            n_fail++;
            $display("FAIL empty_after_fail: got brq_empty=%b, required 1", bus.brq_empty);
        end
    endtask

    task automatic test_correct_pred();
        sb.push_back(model(OP_BNE, 32'h200, 32'h40, 1'b0, 32'd3, 32'd3));
        enq_br(OP_BNE, 32'h200, 32'h40, 1'b0, 4'd0, 32'd3, 4'd0, 32'd3);
        run_cycles(3);
    endtask

    task automatic test_cdb_bypass();
        bus.cdb_tag = 4'd3;
        bus.cdb_val = 32'hFFFF_FFFF;
        sb.push_back(model(OP_BLT, 32'h300, 32'h40, 1'b1, 32'hFFFF_FFFF, 32'd0));
        enq_br(OP_BLT, 32'h300, 32'h40, 1'b1, 4'd3, 32'd0, 4'd0, 32'd0);
        bus.cdb_tag = 4'd0;
        run_cycles(3);
        bus.cdb_tag = 4'd3;
        sb.push_back(model(OP_BLTU, 32'h400, 32'h40, 1'b1, 32'hFFFF_FFFF, 32'd0));
        enq_br(OP_BLTU, 32'h400, 32'h40, 1'b1, 4'd3, 32'd0, 4'd0, 32'd0);
        bus.cdb_tag = 4'd0;
        run_cycles(3);
    endtask

    task automatic test_full_order();
        int  p0;
        bit  consec;
        sb.push_back(model(OP_BGE,  32'h500, 32'h8, 1'b1, 32'd20, 32'd10));
        sb.push_back(model(OP_BGEU, 32'h504, 32'h8, 1'b0, 32'd1,  32'd2));
        sb.push_back(model(OP_BEQ,  32'h508, 32'h8, 1'b0, 32'd1,  32'd2));
        sb.push_back(model(OP_BNE,  32'h50C, 32'h8, 1'b1, 32'd1,  32'd2));
        enq_br(OP_BGE,  32'h500, 32'h8, 1'b1, 4'd7, 32'd0, 4'd0, 32'd10);
        enq_br(OP_BGEU, 32'h504, 32'h8, 1'b0, 4'd0, 32'd1, 4'd0, 32'd2);
        enq_br(OP_BEQ,  32'h508, 32'h8, 1'b0, 4'd0, 32'd1, 4'd0, 32'd2);
        enq_br(OP_BNE,  32'h50C, 32'h8, 1'b1, 4'd0, 32'd1, 4'd0, 32'd2);
        n_tests++;
        if (bus.enq_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL full_ready: got enq_ready=%b, required 0", bus.enq_ready);
        end
        enq_br(OP_BEQ, 32'h600, 32'h8, 1'b0, 4'd0, 32'd1, 4'd0, 32'd1);
        bus.cdb_tag = 4'd7;
        bus.cdb_val = 32'd20;
        run_cycles(1);
        bus.cdb_tag = 4'd0;
        p0 = pulse_cyc.size();
        run_cycles(8);
        n_tests++;
        consec = (pulse_cyc.size() - p0 == 4);
        if (consec)
            for (int i = 1; i < 4; i++)
                if (pulse_cyc[p0+i] - pulse_cyc[p0+i-1] != 1) consec = 1'b0;
        if (!consec) begin
            n_fail++;
            $display("FAIL ordered_burst: got %0d pulses (consecutive=%b), required 4 consecutive",
                     pulse_cyc.size() - p0, consec);
        end
        n_tests++;
        if (bus.brq_empty !== 1'b1 || bus.enq_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL drained: got brq_empty=%b enq_ready=%b, required 1/1",
                     bus.brq_empty, bus.enq_ready);
        end
    endtask

    task automatic test_flush();
        int p0;
        sb.push_back(model(OP_BLT, 32'h700, 32'h10, 1'b1, 32'd1, 32'd0));
        enq_br(OP_BLT, 32'h700, 32'h10, 1'b1, 4'd5, 32'd0, 4'd0, 32'd0);
        enq_br(OP_BEQ, 32'h710, 32'h10, 1'b1, 4'd0, 32'd1, 4'd0, 32'd1);
        enq_br(OP_BEQ, 32'h720, 32'h10, 1'b1, 4'd0, 32'd1, 4'd0, 32'd1);
        bus.cdb_tag = 4'd5;
        bus.cdb_val = 32'd1;
        run_cycles(1);
        bus.cdb_tag = 4'd0;
        p0 = pulse_cyc.size();
        enq_br(OP_BEQ, 32'h800, 32'h10, 1'b0, 4'd0, 32'd5, 4'd0, 32'd5);
        n_tests++;
        if (bus.brq_empty !== 1'b1) begin
            n_fail++;
            $display("FAIL flush_empty: got brq_empty=%b, required 1", bus.brq_empty);
        end
        run_cycles(6);
        n_tests++;
        if (pulse_cyc.size() - p0 != 1 || bus.brq_empty !== 1'b1) begin
            n_fail++;
            $display("FAIL flush_pulses: got %0d pulses empty=%b, required 1 pulse empty=1",
                     pulse_cyc.size() - p0, bus.brq_empty);
        end
    endtask

    task automatic test_stall();
        int p0;
        enq_br(OP_BEQ, 32'h900, 32'h8, 1'b1, 4'd0, 32'd4, 4'd0, 32'd4);
        rdy_in = 1'b0;
        run_cycles(4);
        n_tests++;
        if (bus.brq_empty !== 1'b0) begin
            n_fail++;
            $display("FAIL stall_hold: got brq_empty=%b, required 0", bus.brq_empty);
        end
        sb.push_back(model(OP_BEQ, 32'h900, 32'h8, 1'b1, 32'd4, 32'd4));
        p0 = pulse_cyc.size();
        rdy_in = 1'b1;
        run_cycles(4);
        n_tests++;
        if (pulse_cyc.size() - p0 != 1) begin
            n_fail++;
            $display("FAIL stall_release: got %0d pulses, required 1", pulse_cyc.size() - p0);
        end
        // Stall right after the resolve edge: the pulse must not stretch.
        sb.push_back(model(OP_BNE, 32'h910, 32'h8, 1'b1, 32'd1, 32'd2));
        p0 = pulse_cyc.size();
        enq_br(OP_BNE, 32'h910, 32'h8, 1'b1, 4'd0, 32'd1, 4'd0, 32'd2);
        run_cycles(1);
        rdy_in = 1'b0;
        run_cycles(3);
        rdy_in = 1'b1;
        run_cycles(2);
        n_tests++;
        if (pulse_cyc.size() - p0 != 1) begin
            n_fail++;
            $display("FAIL stall_no_repeat: got %0d pulses, required 1", pulse_cyc.size() - p0);
        end
    endtask

    task automatic test_reset_mid();
        enq_br(OP_BEQ, 32'hA00, 32'h8, 1'b0, 4'd9, 32'd0, 4'd0, 32'd0);
        enq_br(OP_BEQ, 32'hA04, 32'h8, 1'b0, 4'd9, 32'd0, 4'd0, 32'd0);
        rst_in = 1'b1;
        run_cycles(1);
        rst_in = 1'b0;
        n_tests++;
        if ({bus.upd_valid, bus.predict_fail, bus.upd_taken, bus.brq_empty} !== 4'b0001 ||
            bus.redirect_addr !== 32'h0 || bus.upd_idx !== '0 || bus.upd_pc_tag !== '0) begin
            n_fail++;
            $display("FAIL mid_reset: got v=%b f=%b t=%b empty=%b redir=%h idx=%h tag=%h, required 0/0/0/1/0/0/0",
                     bus.upd_valid, bus.predict_fail, bus.upd_taken, bus.brq_empty,
                     bus.redirect_addr, bus.upd_idx, bus.upd_pc_tag);
        end
        bus.cdb_tag = 4'd9;
        bus.cdb_val = 32'd0;
        run_cycles(1);
        bus.cdb_tag = 4'd0;
        run_cycles(4);
        n_tests++;
        if (bus.brq_empty !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_flushed: got brq_empty=%b, required 1", bus.brq_empty);
        end
    endtask

    initial begin
        rst_in             = 1'b1;
        rdy_in             = 1'b1;
        bus.enq_valid      = 1'b0;
        bus.enq_op         = OP_NOP;
        bus.enq_pc         = '0;
        bus.enq_imm        = '0;
        bus.enq_pred_taken = 1'b0;
        bus.enq_rs1_tag    = '0;
        bus.enq_rs2_tag    = '0;
        bus.enq_rs1_val    = '0;
        bus.enq_rs2_val    = '0;
        bus.cdb_tag        = '0;
        bus.cdb_val        = '0;
        @(posedge clk_in);
        #1;

        test_reset();
        test_non_branch();
        test_ready_operands();
        test_correct_pred();
        test_cdb_bypass();
        test_full_order();
        test_flush();
        test_stall();
        test_reset_mid();

        n_tests++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL missing_pulses: got %0d unconsumed expectations, required 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/branch_resolver.md
Name: branch_resolver

Overview:
Resolving end of the fetch-stage branch prediction protocol. Queues each conditional branch the predictor has just predicted, together with its PC, immediate and predicted direction. Snoops the CDB until the branch's operands are known, then evaluates the condition in program order. Returns the 2-bit-counter training update to the predictor and raises predict_fail with the corrected fetch address on a mispredict.

Parameters:
BRQ_SIZE_W, 2, log2 of in-flight branch queue depth (4 entries)
BP_SIZE_W, 7, log2 of predictor table entries; sets upd_idx / upd_pc_tag split

Ports:
clk_in  in  1  clock
rst_in  in  1  synchronous reset, active-high
rdy_in  in  1  global enable; low = stall, all state holds
enq_valid  in  1  predicted conditional branch presented this cycle
enq_op  in  5  decoded op (BEQ/BNE/BLT/BGE/BLTU/BGEU codes from shared defines)
enq_pc  in  32  branch PC
enq_imm  in  32  sign-extended branch offset
enq_pred_taken  in  1  predictor's need_branch for this branch
enq_rs1_tag / enq_rs2_tag  in  4  producer tag; 0 = value already valid
enq_rs1_val / enq_rs2_val  in  32  register value, meaningful when tag = 0
enq_ready  out  1  queue not full
cdb_tag  in  4  broadcast tag; 0 = no broadcast
cdb_val  in  32  broadcast value
upd_valid  out  1  one-cycle pulse: training update for predictor
upd_idx  out  BP_SIZE_W  table index = pc[1+BP_SIZE_W:2]
upd_pc_tag  out  30-BP_SIZE_W  pc[31:2+BP_SIZE_W]
upd_taken  out  1  resolved direction
predict_fail  out  1  one-cycle pulse: head branch mispredicted
redirect_addr  out  32  corrected fetch PC, valid with predict_fail
brq_empty  out  1  no branches in flight

Behaviour:
- Reset (rst_in=1 at a clock edge): count=0, head=tail=0, all entries invalid. upd_valid=0, predict_fail=0, redirect_addr=0, upd_idx=0, upd_pc_tag=0, upd_taken=0. Takes priority over rdy_in.
- rdy_in=0: queue, pointers and operands hold. upd_valid and predict_fail are driven 0 during the stall so no pulse repeats. Data outputs hold.
- Enqueue:
  - Accepted when enq_valid & enq_ready & rdy_in & no flush this cycle. Writes at tail; tail wraps modulo 2^BRQ_SIZE_W.
  - Ops outside the six conditional branches (e.g. JAL) are ignored.
  - enq_ready = (count != 2^BRQ_SIZE_W), combinational from count only. There is no same-cycle dequeue bypass when full.
- Operand capture:
  - Every rdy cycle with cdb_tag != 0, each valid entry with rsX_tag == cdb_tag latches cdb_val and clears the tag to 0.
  - The entry being enqueued this cycle also bypasses: if enq_rsX_tag == cdb_tag != 0, it stores cdb_val with tag 0.
- Resolution (in order, head only, at most one per cycle):
  - The head resolves in a cycle where it is valid and both stored tags are 0 at the start of that cycle. An operand that arrives on the CDB therefore resolves the branch at the earliest on the following cycle.
  - Conditions: BEQ/BNE compare equality; BLT/BGE use signed 32-bit compare; BLTU/BGEU use unsigned compare.
  - Outputs are registered and appear the cycle after the resolve edge: upd_valid=1, upd_idx and upd_pc_tag from the branch PC, upd_taken=outcome.
  - If outcome == pred_taken: dequeue the head only.
  - If outcome != pred_taken: additionally set predict_fail=1 and redirect_addr = outcome ? pc+imm : pc+4 (32-bit wrap). Flush the whole queue (count=0, head=tail), since all younger entries are wrong-path. Any enqueue in that same cycle is dropped.
- Simultaneous enqueue and correct dequeue: count unchanged, both pointers advance.
- brq_empty = (count == 0).
- Count is BRQ_SIZE_W+1 bits wide. Full and empty are distinguished by count, not by pointer equality.

Decomposition:
- Shared defines header, already used by the decoder: branch op codes BEQ..BGEU, tag width 4, NO_TAG=0, BP_SIZE_W.
- One natural sub-module: branch_cond_eval, a combinational op/rs1/rs2 → taken evaluator. It is reusable by the ALU.

Test Plan:
- Ready operands: enq BEQ pc=0x100 imm=0x20 rs1=5 rs2=5 tags 0, pred_taken=0 → two cycles later predict_fail=1, redirect_addr=0x120, upd_valid=1, upd_taken=1, upd_idx=0x40, brq_empty=1.
- Correct prediction: enq BNE pc=0x200, rs1=3 rs2=3, pred_taken=0 → upd_valid=1, upd_taken=0, predict_fail stays 0.
- CDB wakeup and bypass: enq BLT rs1_tag=3 rs2 val=0, with cdb_tag=3 cdb_val=0xFFFFFFFF in the same cycle → signed -1<0 gives taken. With pred_taken=1 → no fail. Repeat with BLTU → not taken; with pred_taken=1 → predict_fail=1, redirect=pc+4.
- Ordering and full: enq 4 branches, head waiting on tag 7 → enq_ready=0 and a 5th enq is dropped. Broadcast tag 7 → the four resolve on consecutive cycles in enqueue order.
- Flush: 3 queued, head mispredicts while enq_valid=1 → count=0, the enq is dropped, no further upd_valid pulses.
- Stall/reset: rdy_in=0 on the resolve cycle → no pulse until rdy_in returns, then exactly one pulse. rst_in mid-queue → brq_empty=1, all outputs 0 next cycle.
